// File: rtl/alu_operand_stage_pkg.sv
// Shared encodings and helpers for the execute-stage operand formation logic.
package alu_operand_stage_pkg;

  localparam int OP_W   = 4;
  localparam int ADDR_W = 5;

  // ALU operation encodings; 0 is AND so a bubble presents a harmless op.
  localparam logic [OP_W-1:0] ALU_OP_AND = 4'h0;
  localparam logic [OP_W-1:0] ALU_OP_OR  = 4'h1;
  localparam logic [OP_W-1:0] ALU_OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] ALU_OP_XOR = 4'h3;
  localparam logic [OP_W-1:0] ALU_OP_SUB = 4'h6;
  localparam logic [OP_W-1:0] ALU_OP_SLT = 4'h7;
  localparam logic [OP_W-1:0] ALU_OP_SLL = 4'h8;
  localparam logic [OP_W-1:0] ALU_OP_SRL = 4'h9;
  localparam logic [OP_W-1:0] ALU_OP_SRA = 4'hA;
  localparam logic [OP_W-1:0] ALU_OP_NOR = 4'hC;

  // Operand source selects.
  localparam logic ALU_SRC_A_REG   = 1'b0;
  localparam logic ALU_SRC_A_SHAMT = 1'b1;
  localparam logic ALU_SRC_B_REG   = 1'b0;
  localparam logic ALU_SRC_B_IMM   = 1'b1;

  // A later stage supplies the operand when it writes the same, non-zero register.
  function automatic logic fwd_hit(input logic wr, input logic [ADDR_W-1:0] rd,
                                   input logic [ADDR_W-1:0] addr);
    return wr && (rd == addr) && (addr != '0);
  endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Forwarding selector for one source operand: EX/MEM beats MEM/WB beats the register file.
module fwd_mux
  import alu_operand_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [N-1:0]      reg_data,
  input  logic              mem_reg_write,
  input  logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [N-1:0]      mem_result,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_rd_addr,
  input  logic [N-1:0]      wb_result,
  output logic [N-1:0]      operand
);

  // Youngest producer wins; register 0 never matches.
  always_comb begin
    operand = reg_data;
    if (fwd_hit(mem_reg_write, mem_rd_addr, addr)) begin
      operand = mem_result;
    end else if (fwd_hit(wb_reg_write, wb_rd_addr, addr)) begin
      operand = wb_result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with forwarding and ALU source selection feeding the ALU.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int N       = 32,
  parameter int IMM_W   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [OP_W-1:0]    id_op_code,
  input  logic [ADDR_W-1:0]  id_rs_addr,
  input  logic [ADDR_W-1:0]  id_rt_addr,
  input  logic [N-1:0]       id_rs_data,
  input  logic [N-1:0]       id_rt_data,
  input  logic [IMM_W-1:0]   id_imm,
  input  logic               id_imm_sext,
  input  logic [SHAMT_W-1:0] id_shamt,
  input  logic               id_src_a,
  input  logic               id_src_b,
  input  logic               id_reg_write,
  input  logic [ADDR_W-1:0]  id_rd_addr,
  input  logic               mem_reg_write,
  input  logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [N-1:0]       mem_result,
  input  logic               wb_reg_write,
  input  logic [ADDR_W-1:0]  wb_rd_addr,
  input  logic [N-1:0]       wb_result,
  output logic [N-1:0]       alu_x,
  output logic [N-1:0]       alu_y,
  output logic [OP_W-1:0]    alu_op_code,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic [ADDR_W-1:0]  ex_rd_addr,
  output logic [N-1:0]       ex_store_data,
  output logic [31:0]        bubble_count
);

  logic               valid_reg;
  logic [OP_W-1:0]    op_reg;
  logic [ADDR_W-1:0]  rs_addr_reg;
  logic [ADDR_W-1:0]  rt_addr_reg;
  logic [N-1:0]       rs_data_reg;
  logic [N-1:0]       rt_data_reg;
  logic [IMM_W-1:0]   imm_reg;
  logic               sext_reg;
  logic [SHAMT_W-1:0] shamt_reg;
  logic               src_a_reg;
  logic               src_b_reg;
  logic               reg_write_reg;
  logic [ADDR_W-1:0]  rd_addr_reg;
  logic [31:0]        bubble_count_reg;

  logic               capture_bubble;
  logic [N-1:0]       ext_imm;
  logic [ADDR_W-1:0]  src_addr    [2];
  logic [N-1:0]       src_data    [2];
  logic [N-1:0]       fwd_operand [2];

  // Flush inserts an all-zero bubble, stall holds, otherwise take the decoded instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      op_reg        <= '0;
      rs_addr_reg   <= '0;
      rt_addr_reg   <= '0;
      rs_data_reg   <= '0;
      rt_data_reg   <= '0;
      imm_reg       <= '0;
      sext_reg      <= 1'b0;
      shamt_reg     <= '0;
      src_a_reg     <= 1'b0;
      src_b_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      rd_addr_reg   <= '0;
    end else if (flush) begin
      valid_reg     <= 1'b0;
      op_reg        <= '0;
      rs_addr_reg   <= '0;
      rt_addr_reg   <= '0;
      rs_data_reg   <= '0;
      rt_data_reg   <= '0;
      imm_reg       <= '0;
      sext_reg      <= 1'b0;
      shamt_reg     <= '0;
      src_a_reg     <= 1'b0;
      src_b_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      rd_addr_reg   <= '0;
    end else if (!stall) begin
      valid_reg     <= id_valid;
      op_reg        <= id_op_code;
      rs_addr_reg   <= id_rs_addr;
      rt_addr_reg   <= id_rt_addr;
      rs_data_reg   <= id_rs_data;
      rt_data_reg   <= id_rt_data;
      imm_reg       <= id_imm;
      sext_reg      <= id_imm_sext;
      shamt_reg     <= id_shamt;
      src_a_reg     <= id_src_a;
      src_b_reg     <= id_src_b;
      reg_write_reg <= id_reg_write;
      rd_addr_reg   <= id_rd_addr;
    end
  end

  // A bubble is any capture that lands valid=0; a held stall captures nothing.
  assign capture_bubble = flush || (!stall && !id_valid);

  // Saturating bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count_reg <= '0;
    end else if (capture_bubble && (bubble_count_reg != '1)) begin
      bubble_count_reg <= bubble_count_reg + 32'd1;
    end
  end

  assign src_addr[0] = rs_addr_reg;
  assign src_addr[1] = rt_addr_reg;
  assign src_data[0] = rs_data_reg;
  assign src_data[1] = rt_data_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_mux #(.N(N)) u_fwd_mux (
      .addr          (src_addr[gi]),
      .reg_data      (src_data[gi]),
      .mem_reg_write (mem_reg_write),
      .mem_rd_addr   (mem_rd_addr),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd_addr    (wb_rd_addr),
      .wb_result     (wb_result),
      .operand       (fwd_operand[gi])
    );
  end

  assign ext_imm = sext_reg ? {{(N-IMM_W){imm_reg[IMM_W-1]}}, imm_reg}
                            : {{(N-IMM_W){1'b0}}, imm_reg};

  // Shifts take the amount on x, so src_a selects the zero-extended shamt.
  assign alu_x = (src_a_reg == ALU_SRC_A_SHAMT) ? {{(N-SHAMT_W){1'b0}}, shamt_reg}
                                                : fwd_operand[0];
  assign alu_y = (src_b_reg == ALU_SRC_B_IMM) ? ext_imm : fwd_operand[1];

  assign alu_op_code   = op_reg;
  assign ex_valid      = valid_reg;
  assign ex_reg_write  = reg_write_reg & valid_reg;
  assign ex_rd_addr    = rd_addr_reg;
  assign ex_store_data = fwd_operand[1];
  assign bubble_count  = bubble_count_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: a behavioural model plus directed literal checks.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, id_valid;
  logic [3:0]  id_op_code;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        id_imm_sext;
  logic [4:0]  id_shamt;
  logic        id_src_a, id_src_b, id_reg_write;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic [31:0] alu_x, alu_y, ex_store_data, bubble_count;
  logic [3:0]  alu_op_code;
  logic        ex_valid, ex_reg_write;
  logic [4:0]  ex_rd_addr;

  int tests = 0;
  int fails = 0;

  alu_operand_stage #(.N(32), .IMM_W(16), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_op_code(id_op_code),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_imm_sext(id_imm_sext), .id_shamt(id_shamt),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_reg_write(id_reg_write), .id_rd_addr(id_rd_addr),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op_code(alu_op_code),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr),
    .ex_store_data(ex_store_data), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction the stage currently holds, as a record of decoded fields.
  typedef struct {
    bit          valid;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    bit          sext, sa, sb, rw;
    logic [4:0]  shamt;
  } entry_t;

  entry_t      held;
  longint      m_bubbles;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      held = '{default: 0};
      m_bubbles = 0;
    end else if (flush) begin
      held = '{default: 0};
      if (m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
    end else if (!stall) begin
      held.valid = id_valid;  held.op = id_op_code;
      held.rs = id_rs_addr;   held.rt = id_rt_addr;   held.rd = id_rd_addr;
      held.rs_data = id_rs_data; held.rt_data = id_rt_data;
      held.imm = id_imm;      held.sext = id_imm_sext; held.shamt = id_shamt;
      held.sa = id_src_a;     held.sb = id_src_b;     held.rw = id_reg_write;
      if (!id_valid && m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
    end
  end

  function automatic logic [31:0] operand_of(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d;
    if (mem_reg_write && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return d;
  endfunction

  function automatic logic [31:0] imm_value(input logic [15:0] imm, input bit sext);
    logic [31:0] v;
    v = {16'd0, imm};
    if (sext && imm >= 16'h8000) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  // Every cycle, away from the edge, the outputs must match the model's view.
  always @(negedge clk) begin
    logic [31:0] ex_x, ex_y, ex_sd;
    ex_sd = operand_of(held.rt, held.rt_data);
    ex_x  = held.sa ? 32'(held.shamt) : operand_of(held.rs, held.rs_data);
    ex_y  = held.sb ? imm_value(held.imm, held.sext) : ex_sd;
    chk("cyc_alu_x", alu_x, ex_x);
    chk("cyc_alu_y", alu_y, ex_y);
    chk("cyc_op", 32'(alu_op_code), 32'(held.op));
    chk("cyc_valid", 32'(ex_valid), 32'(held.valid));
    chk("cyc_reg_write", 32'(ex_reg_write), 32'(held.valid && held.rw));
    chk("cyc_rd", 32'(ex_rd_addr), 32'(held.rd));
    chk("cyc_store", ex_store_data, ex_sd);
    chk("cyc_bubbles", bubble_count, m_bubbles[31:0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; id_valid = 0; id_op_code = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_imm_sext = 0; id_shamt = 0;
    id_src_a = 0; id_src_b = 0; id_reg_write = 0;
    mem_reg_write = 0; mem_rd_addr = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd_addr = 0; wb_result = 0;
  endtask

  task automatic instr(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd);
    id_valid = 1; id_op_code = op; id_rs_addr = rs; id_rs_data = rsd;
    id_rt_addr = rt; id_rt_data = rtd; id_rd_addr = rd; id_reg_write = 1;
    id_src_a = ALU_SRC_A_REG; id_src_b = ALU_SRC_B_REG;
  endtask

  initial begin
    logic [31:0] cnt0, x0;
    rst = 1;
    idle();
    #2;
    chk("reset_x", alu_x, 32'd0);
    chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_count", bubble_count, 32'd0);
    step();
    rst = 0;
    step();

    // ADD with no hazards
    cnt0 = bubble_count;
    instr(ALU_OP_ADD, 5'd1, 32'h5, 5'd2, 32'h7, 5'd4);
    step();
    chk("add_x", alu_x, 32'h5);
    chk("add_y", alu_y, 32'h7);
    chk("add_op", 32'(alu_op_code), 32'(ALU_OP_ADD));
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_count", bubble_count, cnt0);

    // forwarding priority
    instr(ALU_OP_SUB, 5'd3, 32'h11, 5'd2, 32'h7, 5'd5);
    step();
    mem_reg_write = 1; mem_rd_addr = 3; mem_result = 32'hAA;
    wb_reg_write = 1;  wb_rd_addr = 3;  wb_result = 32'hBB;
    #1 chk("fwd_mem", alu_x, 32'hAA);
    mem_reg_write = 0;
    #1 chk("fwd_wb", alu_x, 32'hBB);

    // register 0 never forwarded
    instr(ALU_OP_OR, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6);
    mem_reg_write = 1; mem_rd_addr = 0; mem_result = 32'h1234;
    wb_reg_write = 1;  wb_rd_addr = 0;  wb_result = 32'h5678;
    step();
    chk("r0_x", alu_x, 32'h0);
    chk("r0_store", ex_store_data, 32'h0);
    mem_reg_write = 0; wb_reg_write = 0;

    // immediate extension and shift
    instr(ALU_OP_ADD, 5'd1, 32'h9, 5'd2, 32'h7, 5'd7);
    id_src_b = ALU_SRC_B_IMM; id_imm = 16'hFFFF; id_imm_sext = 1;
    step();
    chk("imm_sext", alu_y, 32'hFFFF_FFFF);
    chk("imm_store", ex_store_data, 32'h7);
    id_imm_sext = 0;
    step();
    chk("imm_zext", alu_y, 32'h0000_FFFF);
    instr(ALU_OP_SRA, 5'd9, 32'h3, 5'd2, 32'h8000_0000, 5'd8);
    id_src_a = ALU_SRC_A_SHAMT; id_shamt = 5'd4;
    step();
    chk("sra_x", alu_x, 32'd4);
    chk("sra_y", alu_y, 32'h8000_0000);

    // stall holds, then flush+stall inserts a counted bubble
    instr(ALU_OP_XOR, 5'd10, 32'hCAFE, 5'd11, 32'hBEEF, 5'd12);
    step();
    x0 = alu_x; cnt0 = bubble_count;
    stall = 1; id_valid = 0; id_rs_data = 32'h1; id_rs_addr = 5'd13;
    for (int i = 0; i < 3; i++) step();
    chk("stall_x", alu_x, 32'hCAFE);
    chk("stall_x_same", alu_x, x0);
    chk("stall_count", bubble_count, cnt0);
    flush = 1;
    step();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_op", 32'(alu_op_code), 32'd0);
    chk("flush_count", bubble_count, cnt0 + 32'd1);
    flush = 0; stall = 0;

    // mixed pattern sweep, checked by the per-cycle compare
    for (int i = 0; i < 24; i++) begin
      instr(4'(i % 11), 5'(i % 4), 32'h100 + 32'(i), 5'((i + 1) % 4), 32'h200 + 32'(i), 5'(i % 6));
      id_valid = (i % 5) != 0;
      id_src_b = (i % 3) == 0; id_imm = 16'(16'h7FF0 + 16'(i * 4)); id_imm_sext = i[0];
      id_src_a = (i % 7) == 0; id_shamt = 5'(i);
      mem_reg_write = i[1]; mem_rd_addr = 5'((i + 2) % 4); mem_result = 32'hA000 + 32'(i);
      wb_reg_write = i[2];  wb_rd_addr = 5'(i % 4);        wb_result = 32'hB000 + 32'(i);
      stall = (i % 6) == 4; flush = (i % 8) == 7;
      step();
    end
    idle();

    // async reset mid-stream, no clock edge
    instr(ALU_OP_ADD, 5'd1, 32'h55, 5'd2, 32'h66, 5'd3);
    step();
    #2 rst = 1;
    #1;
    chk("rst_mid_x", alu_x, 32'd0);
    chk("rst_mid_y", alu_y, 32'd0);
    chk("rst_mid_valid", 32'(ex_valid), 32'd0);
    chk("rst_mid_rw", 32'(ex_reg_write), 32'd0);
    chk("rst_mid_count", bubble_count, 32'd0);
    step();
    rst = 0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
